// File: rtl/wb_ctrl_pipe.sv
// Writeback-control decoder and pipeline carrier: decodes MemtoReg/RegWrite/dest in ID
// and shifts them through STAGES registers to WB, with stall, flush, $0 suppression and a retire counter.
module wb_ctrl_pipe #(
  parameter int STAGES = 3,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               opcode,
  input  logic [DEST_W-1:0]        rt,
  input  logic [DEST_W-1:0]        rd,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     wb_valid,
  output logic                     wb_mem_to_reg,
  output logic                     wb_reg_write,
  output logic [DEST_W-1:0]        wb_dest,
  output logic [STAGES-1:0]        pend_reg_write,
  output logic [STAGES*DEST_W-1:0] pend_dest,
  output logic                     illegal_op,
  output logic [CNT_W-1:0]         retire_count
);

  logic              decValid;
  logic              decMemToReg;
  logic              decRegWrite;
  logic [DEST_W-1:0] decDest;
  logic              decIllegal;

  logic [STAGES-1:0]        stageValid_q, stageValid_d;
  logic [STAGES-1:0]        stageMemToReg_q, stageMemToReg_d;
  logic [STAGES-1:0]        stageRegWrite_q, stageRegWrite_d;
  logic [STAGES*DEST_W-1:0] stageDest_q, stageDest_d;
  logic                     illegal_q, illegal_d;
  logic [CNT_W-1:0]         count_q, count_d;

  // Unknown opcodes decode as bubbles; the illegal flag is only meaningful when in_valid is set.
  always_comb begin
    decValid    = 1'b0;
    decMemToReg = 1'b0;
    decRegWrite = 1'b0;
    decDest     = '0;
    decIllegal  = 1'b0;
    if (in_valid) begin
      case (opcode)
        6'b000000: begin
          decValid    = 1'b1;
          decRegWrite = 1'b1;
          decDest     = rd;
        end
        6'b001000, 6'b001101, 6'b001100, 6'b001010: begin
          decValid    = 1'b1;
          decRegWrite = 1'b1;
          decDest     = rt;
        end
        6'b100011: begin
          decValid    = 1'b1;
          decRegWrite = 1'b1;
          decMemToReg = 1'b1;
          decDest     = rt;
        end
        6'b101011, 6'b000010, 6'b000100, 6'b000101: begin
          decValid = 1'b1;
        end
        6'b111111: begin
          decValid = 1'b0;
        end
        default: begin
          decIllegal = 1'b1;
        end
      endcase
      if (decDest == '0) decRegWrite = 1'b0;
    end
  end

  always_comb begin
    stageValid_d    = stageValid_q;
    stageMemToReg_d = stageMemToReg_q;
    stageRegWrite_d = stageRegWrite_q;
    stageDest_d     = stageDest_q;
    illegal_d       = illegal_q;
    count_d         = count_q;

    if (!stall) begin
      for (int i = 1; i < STAGES; i++) begin
        stageValid_d[i]                  = stageValid_q[i-1];
        stageMemToReg_d[i]               = stageMemToReg_q[i-1];
        stageRegWrite_d[i]               = stageRegWrite_q[i-1];
        stageDest_d[i*DEST_W +: DEST_W]  = stageDest_q[(i-1)*DEST_W +: DEST_W];
      end
      illegal_d = decIllegal && !flush;
      if (stageValid_q[STAGES-1] && stageRegWrite_q[STAGES-1] && (count_q != '1))
        count_d = count_q + 1'b1;
    end

    // Flush wins even under stall: only stage 0 is replaced, older stages keep their state.
    if (flush) begin
      stageValid_d[0]         = 1'b0;
      stageMemToReg_d[0]      = 1'b0;
      stageRegWrite_d[0]      = 1'b0;
      stageDest_d[DEST_W-1:0] = '0;
    end else if (!stall) begin
      stageValid_d[0]         = decValid;
      stageMemToReg_d[0]      = decMemToReg;
      stageRegWrite_d[0]      = decRegWrite;
      stageDest_d[DEST_W-1:0] = decDest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid_q    <= '0;
      stageMemToReg_q <= '0;
      stageRegWrite_q <= '0;
      stageDest_q     <= '0;
      illegal_q       <= 1'b0;
      count_q         <= '0;
    end else begin
      stageValid_q    <= stageValid_d;
      stageMemToReg_q <= stageMemToReg_d;
      stageRegWrite_q <= stageRegWrite_d;
      stageDest_q     <= stageDest_d;
      illegal_q       <= illegal_d;
      count_q         <= count_d;
    end
  end

  assign wb_valid       = stageValid_q[STAGES-1];
  assign wb_mem_to_reg  = stageMemToReg_q[STAGES-1];
  assign wb_reg_write   = stageRegWrite_q[STAGES-1];
  assign wb_dest        = stageDest_q[(STAGES-1)*DEST_W +: DEST_W];
  assign pend_reg_write = stageRegWrite_q;
  assign pend_dest      = stageDest_q;
  assign illegal_op     = illegal_q;
  assign retire_count   = count_q;

endmodule

// File: doc/wb_ctrl_pipe.md
Name: wb_ctrl_pipe

Overview:
Parametrised writeback-control decoder and pipeline carrier for the MIPS pipeline core. It decodes the opcode in ID into MemtoReg, RegWrite and destination register, then carries these through STAGES pipeline registers to the WB stage. It supports stall, flush/bubble insertion, $0 write suppression, illegal-opcode flagging and a retired-write counter. It also exposes per-stage pending-write information for forwarding and hazard units.

Parameters:
STAGES, 3, number of register stages between decode and WB (ID/EX, EX/MEM, MEM/WB); legal range 1..8
DEST_W, 5, register index width
CNT_W, 16, retired-write counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  ID holds a real instruction this cycle
opcode  input  6  instruction [31:26]
rt  input  DEST_W  instruction rt field
rd  input  DEST_W  instruction rd field
stall  input  1  freeze all stages
flush  input  1  load bubble into stage 0
wb_valid  output  1  stage STAGES-1 holds a real instruction
wb_mem_to_reg  output  1  WB mux select: 1 = memory data
wb_reg_write  output  1  register-file write enable
wb_dest  output  DEST_W  register-file write index
pend_reg_write  output  STAGES  bit i = stage i will write a register
pend_dest  output  STAGES*DEST_W  stage i dest at bits [i*DEST_W +: DEST_W]
illegal_op  output  1  registered pulse: an unknown opcode entered stage 0
retire_count  output  CNT_W  saturating count of retired register writes

Behaviour:
- Decode is combinational, in front of stage 0. Entry = {valid, mem_to_reg, reg_write, dest}.
- Opcode table:
  - 000000 R-type: RW=1, M2R=0, dest=rd
  - 001000 addi, 001101 ori, 001100 andi, 001010 slti: RW=1, M2R=0, dest=rt
  - 100011 lw: RW=1, M2R=1, dest=rt
  - 101011 sw, 000010 j, 000100 beq, 000101 bne: RW=0, M2R=0, dest=0
  - 111111 NOP: RW=0, M2R=0, dest=0, valid=0
  - any other opcode: treated as NOP and illegal_op=1 on the next cycle, provided in_valid=1, stall=0 and flush=0
- $0 suppression: if decoded dest==0, RW is forced to 0.
- in_valid=0 decodes to a bubble: all fields 0.
- Stage update on the rising clk edge, in priority order:
  - stall=1, flush=0: all stages hold.
  - stall=1, flush=1: stage 0 becomes a bubble; stages 1..STAGES-1 hold.
  - stall=0, flush=1: stage 0 becomes a bubble; stage i takes stage i-1.
  - stall=0, flush=0: stage 0 takes the decoded entry; stage i takes stage i-1.
- Latency: an instruction sampled at edge N appears on the wb_* outputs after edge N+STAGES-1 (stage STAGES-1), when there are no stalls. Each stall cycle adds one cycle.
- wb_* outputs are driven directly from stage STAGES-1 (registered, no combinational path from inputs).
- pend_reg_write and pend_dest are stage register contents, bubbles included (bubble: 0/0).
- illegal_op is a single-cycle registered pulse. It is cleared the next cycle unless another illegal opcode is accepted. It holds its value while stall=1.
- retire_count increments by 1 on each edge where stall=0 and stage STAGES-1 has valid=1 and RW=1 before that edge. It saturates at all-ones with no wrap.
- Reset, asserted at any time including mid-pipeline: all stages become bubbles; wb_valid, wb_mem_to_reg, wb_reg_write and wb_dest are 0; pend_* are 0; illegal_op is 0; retire_count is 0. Reset takes effect immediately, asynchronously. The first post-reset capture is on the first rising edge after rst deasserts.
- STAGES=1: stage 0 is the WB register; the shift rule degenerates accordingly.

Test Plan:
- Reset mid-flow: issue lw rt=5, assert rst for half a cycle -> all outputs 0 immediately; after release with no instructions issued, wb_valid stays 0 and retire_count=0.
- Latency/decode, STAGES=3: issue lw rt=7 at edge 0, then R-type rd=9, then sw -> at edge 2 wb shows M2R=1, RW=1, dest=7; edge 3 shows M2R=0, RW=1, dest=9; edge 4 shows RW=0, wb_valid=1; retire_count=2.
- $0 suppression: addi rt=0 -> at WB, wb_valid=1, wb_reg_write=0, dest=0; retire_count unchanged.
- Stall/flush: with lw rt=3 in stage 0, stall=1 for 2 cycles -> pend_dest[0]=3 held and wb unchanged. Then stall=1 and flush=1 for one cycle -> stage 0 becomes a bubble while stages 1-2 hold. Then release -> the bubble reaches WB with wb_valid=0.
- Illegal opcode: opcode 111000 with in_valid=1 -> illegal_op=1 for exactly 1 cycle; the entry retires as wb_valid=0, RW=0.
- Counter saturation, CNT_W=4: issue 20 consecutive R-type instructions with rd=1 -> retire_count stops at 15 and does not wrap.
